// File: rtl/circuito_exp5_if.sv
`default_nettype none
// ============================================================================
// Module   : circuito_exp5_if
// Brief    : Player-facing signal bundle of the Genius game (buttons, start,
//            result flags, play LEDs).
// Revision : 1.0 - initial release
// ============================================================================
interface circuito_exp5_if;
  logic       jogar;
  logic [3:0] botoes;
  logic       ganhou;
  logic       perdeu;
  logic       pronto;
  logic [3:0] leds;

  modport master (
    output jogar,
    output botoes,
    input  ganhou,
    input  perdeu,
    input  pronto,
    input  leds
  );

  modport slave (
    input  jogar,
    input  botoes,
    output ganhou,
    output perdeu,
    output pronto,
    output leds
  );
endinterface : circuito_exp5_if
`default_nettype wire

// File: rtl/circuito_exp5.sv
`default_nettype none
// ============================================================================
// Module   : circuito_exp5
// Brief    : Genius memory game top: control FSM plus datapath (sequence ROM,
//            play/limit counters, play register, optional timeout counter).
//            Optional feature macro: TIMEOUT_EN (play timeout, fim_timeout).
// Revision : 1.0 - initial release
// ============================================================================
module circuito_exp5 #(
  parameter int TIMEOUT_CYCLES = 3000
) (
  input  wire          clock,
  input  wire          reset,
  circuito_exp5_if.slave bus,
  output logic         db_igualE,
  output logic         db_igualL,
  output logic [6:0]   db_contagem,
  output logic [6:0]   db_memoria,
  output logic [6:0]   db_estado,
  output logic [6:0]   db_jogadafeita,
  output logic         db_clock,
  output logic         db_tem_jogada,
  output logic         db_timeout,
  output logic         db_contaL,
  output logic [6:0]   db_limite
);

  typedef enum logic [3:0] {
    S_INICIAL        = 4'h0,
    S_PREPARACAO     = 4'h1,
    S_ESPERA_JOGADA  = 4'h2,
    S_REGISTRA       = 4'h3,
    S_COMPARACAO     = 4'h4,
    S_PROXIMA_JOGADA = 4'h5,
    S_PROXIMA_RODADA = 4'h7,
    S_FIM_ACERTOU    = 4'hA,
    S_FIM_TIMEOUT    = 4'hD,
    S_FIM_ERROU      = 4'hE
  } state_t;

  state_t     r_state;
  state_t     w_next;

  logic [3:0] r_cont_e;
  logic [3:0] r_cont_l;
  logic [3:0] r_jogada;
  logic       r_tem_jogada_d;

  logic [3:0] w_rom_data;
  logic       w_tem_jogada;
  logic       w_jogada;
  logic       w_igual_e;
  logic       w_igual_l;
  logic       w_timeout;

  logic       w_zera_e;
  logic       w_conta_e;
  logic       w_zera_l;
  logic       w_conta_l;
  logic       w_zera_reg;
  logic       w_registra;
  logic       w_zera_t;
  logic       w_conta_t;

  // Active-low segments, bit order gfedcba.
  function automatic logic [6:0] hex7seg(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  always_comb begin
    w_rom_data = 4'b0000;
    case (r_cont_e)
      4'd0:    w_rom_data = 4'b0001;
      4'd1:    w_rom_data = 4'b0010;
      4'd2:    w_rom_data = 4'b0100;
      4'd3:    w_rom_data = 4'b1000;
      4'd4:    w_rom_data = 4'b0100;
      4'd5:    w_rom_data = 4'b0010;
      4'd6:    w_rom_data = 4'b0001;
      4'd7:    w_rom_data = 4'b0001;
      4'd8:    w_rom_data = 4'b0010;
      4'd9:    w_rom_data = 4'b0010;
      4'd10:   w_rom_data = 4'b0100;
      4'd11:   w_rom_data = 4'b0100;
      4'd12:   w_rom_data = 4'b1000;
      4'd13:   w_rom_data = 4'b1000;
      4'd14:   w_rom_data = 4'b0001;
      default: w_rom_data = 4'b0100;
    endcase
  end

  // A held button yields a single pulse: only the 0->1 transition counts.
  assign w_tem_jogada = |bus.botoes;
  assign w_jogada     = w_tem_jogada & ~r_tem_jogada_d;
  assign w_igual_e    = (r_cont_e == r_cont_l);
  assign w_igual_l    = (r_cont_l == 4'hF);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tem_jogada_d <= 1'b0;
    end else begin
      r_tem_jogada_d <= w_tem_jogada;
    end
  end

`ifdef TIMEOUT_EN
  localparam int c_TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [c_TMO_W-1:0] r_tmo_cnt;

  always_ff @(posedge clock) begin
    if (reset || w_zera_t) begin
      r_tmo_cnt <= '0;
    end else if (w_conta_t) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_tmo;

  assign w_timeout    = 1'b0;
  assign w_unused_tmo = w_zera_t ^ w_conta_t ^ (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cont_e <= 4'd0;
      r_cont_l <= 4'd0;
      r_jogada <= 4'd0;
    end else begin
      if (w_zera_e) begin
        r_cont_e <= 4'd0;
      end else if (w_conta_e) begin
        r_cont_e <= r_cont_e + 4'd1;
      end
      if (w_zera_l) begin
        r_cont_l <= 4'd0;
      end else if (w_conta_l) begin
        r_cont_l <= r_cont_l + 4'd1;
      end
      if (w_zera_reg) begin
        r_jogada <= 4'd0;
      end else if (w_registra) begin
        r_jogada <= bus.botoes;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_INICIAL;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_zera_e   = 1'b0;
    w_conta_e  = 1'b0;
    w_zera_l   = 1'b0;
    w_conta_l  = 1'b0;
    w_zera_reg = 1'b0;
    w_registra = 1'b0;
    w_zera_t   = 1'b0;
    w_conta_t  = 1'b0;
    case (r_state)
      S_INICIAL: begin
        if (bus.jogar) w_next = S_PREPARACAO;
      end
      S_PREPARACAO: begin
        w_zera_e   = 1'b1;
        w_zera_l   = 1'b1;
        w_zera_reg = 1'b1;
        w_zera_t   = 1'b1;
        w_next     = S_ESPERA_JOGADA;
      end
      S_ESPERA_JOGADA: begin
        w_conta_t = 1'b1;
        // A press in the same cycle as the timeout still counts as a play.
        if (w_jogada)       w_next = S_REGISTRA;
        else if (w_timeout) w_next = S_FIM_TIMEOUT;
      end
      S_REGISTRA: begin
        w_registra = 1'b1;
        w_zera_t   = 1'b1;
        w_next     = S_COMPARACAO;
      end
      S_COMPARACAO: begin
        if (r_jogada != w_rom_data) w_next = S_FIM_ERROU;
        else if (!w_igual_e)        w_next = S_PROXIMA_JOGADA;
        else if (w_igual_l)         w_next = S_FIM_ACERTOU;
        else                        w_next = S_PROXIMA_RODADA;
      end
      S_PROXIMA_JOGADA: begin
        w_conta_e = 1'b1;
        w_next    = S_ESPERA_JOGADA;
      end
      S_PROXIMA_RODADA: begin
        w_conta_l = 1'b1;
        w_zera_e  = 1'b1;
        w_zera_t  = 1'b1;
        w_next    = S_ESPERA_JOGADA;
      end
      S_FIM_ACERTOU, S_FIM_ERROU, S_FIM_TIMEOUT: begin
        if (bus.jogar) w_next = S_PREPARACAO;
      end
      default: w_next = S_INICIAL;
    endcase
  end

  assign bus.ganhou = (r_state == S_FIM_ACERTOU);
  assign bus.perdeu = (r_state == S_FIM_ERROU) || (r_state == S_FIM_TIMEOUT);
  assign bus.pronto = (r_state == S_FIM_ACERTOU) || (r_state == S_FIM_ERROU) ||
                      (r_state == S_FIM_TIMEOUT);
  assign bus.leds   = r_jogada;

  assign db_igualE      = w_igual_e;
  assign db_igualL      = w_igual_l;
  assign db_contagem    = hex7seg(r_cont_e);
  assign db_memoria     = hex7seg(w_rom_data);
  assign db_estado      = hex7seg(r_state);
  assign db_jogadafeita = hex7seg(r_jogada);
  assign db_clock       = clock;
  assign db_tem_jogada  = w_tem_jogada;
  assign db_timeout     = (r_state == S_FIM_TIMEOUT);
  assign db_contaL      = (r_state == S_PROXIMA_RODADA);
  assign db_limite      = hex7seg(r_cont_l);

endmodule : circuito_exp5
`default_nettype wire

// File: tb/tb_circuito_exp5.sv
`default_nettype none
// ============================================================================
// Module   : tb_circuito_exp5
// Brief    : Directed self-checking bench for the Genius game top.
// Revision : 1.0 - initial release
// ============================================================================
module tb_circuito_exp5;

  logic       clk = 1'b0;
  logic       reset;
  logic       db_igualE, db_igualL, db_clock, db_tem_jogada, db_timeout, db_contaL;
  logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita, db_limite;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_contal = 0;

  logic [3:0] rom [16] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd4, 4'd2, 4'd1, 4'd1,
                           4'd2, 4'd2, 4'd4, 4'd4, 4'd8, 4'd8, 4'd1, 4'd4};

  // Expected 7-seg codes (active-low gfedcba)
  localparam logic [6:0] c_SEG_0 = 7'h40;
  localparam logic [6:0] c_SEG_1 = 7'h79;
  localparam logic [6:0] c_SEG_2 = 7'h24;
  localparam logic [6:0] c_SEG_3 = 7'h30;
  localparam logic [6:0] c_SEG_4 = 7'h19;
  localparam logic [6:0] c_SEG_A = 7'h08;
  localparam logic [6:0] c_SEG_E = 7'h06;
  localparam logic [6:0] c_SEG_F = 7'h0E;

  circuito_exp5_if bus ();

  always #5 clk = ~clk;

  circuito_exp5 #(.TIMEOUT_CYCLES(3000)) dut (
    .clock          (clk),
    .reset          (reset),
    .bus            (bus),
    .db_igualE      (db_igualE),
    .db_igualL      (db_igualL),
    .db_contagem    (db_contagem),
    .db_memoria     (db_memoria),
    .db_estado      (db_estado),
    .db_jogadafeita (db_jogadafeita),
    .db_clock       (db_clock),
    .db_tem_jogada  (db_tem_jogada),
    .db_timeout     (db_timeout),
    .db_contaL      (db_contaL),
    .db_limite      (db_limite)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (db_contaL) n_contal++;
    end
  endtask

  task automatic press(input logic [3:0] b);
    bus.botoes = b;
    tick(4);
    bus.botoes = 4'd0;
    tick(2);
  endtask

  initial begin
    reset      = 1'b1;
    bus.jogar  = 1'b0;
    bus.botoes = 4'd0;
    tick(1);
    reset = 1'b0;
    tick(10);
    check("rst_estado",   16'(db_estado),   16'(c_SEG_0));
    check("rst_pronto",   16'(bus.pronto),  16'd0);
    check("rst_ganhou",   16'(bus.ganhou),  16'd0);
    check("rst_perdeu",   16'(bus.perdeu),  16'd0);
    check("rst_leds",     16'(bus.leds),    16'd0);
    check("rst_contagem", 16'(db_contagem), 16'(c_SEG_0));
    check("rst_memoria",  16'(db_memoria),  16'(c_SEG_1));
    check("rst_limite",   16'(db_limite),   16'(c_SEG_0));
    check("rst_igualE",   16'(db_igualE),   16'd1);
    check("rst_igualL",   16'(db_igualL),   16'd0);

    // Round 1, button held for 10 cycles
    bus.jogar = 1'b1;
    tick(5);
    bus.jogar = 1'b0;
    tick(1);
    check("start_estado", 16'(db_estado), 16'(c_SEG_2));
    n_contal   = 0;
    bus.botoes = 4'b0001;
    tick(1);
    check("tem_jogada", 16'(db_tem_jogada), 16'd1);
    tick(9);
    bus.botoes = 4'd0;
    tick(2);
    check("r1_limite",   16'(db_limite),   16'(c_SEG_1));
    check("r1_contagem", 16'(db_contagem), 16'(c_SEG_0));
    check("r1_contal",   16'(n_contal),    16'd1);
    check("r1_estado",   16'(db_estado),   16'(c_SEG_2));
    check("r1_leds",     16'(bus.leds),    16'b0001);

    press(4'b0001); press(4'b0010);
    press(4'b0001); press(4'b0010); press(4'b0100);
    check("r3_limite", 16'(db_limite), 16'(c_SEG_3));
    check("r3_estado", 16'(db_estado), 16'(c_SEG_2));
    check("r3_contal", 16'(n_contal),  16'd3);

    press(4'b0001); press(4'b0010); press(4'b0010);
    check("err_estado",   16'(db_estado),   16'(c_SEG_E));
    check("err_perdeu",   16'(bus.perdeu),  16'd1);
    check("err_pronto",   16'(bus.pronto),  16'd1);
    check("err_ganhou",   16'(bus.ganhou),  16'd0);
    check("err_leds",     16'(bus.leds),    16'b0010);
    check("err_contagem", 16'(db_contagem), 16'(c_SEG_2));
    check("err_memoria",  16'(db_memoria),  16'(c_SEG_4));

    // Restart from fim_errou
    bus.jogar = 1'b1;
    tick(2);
    bus.jogar = 1'b0;
    tick(1);
    check("rs_leds",   16'(bus.leds),  16'd0);
    check("rs_limite", 16'(db_limite), 16'(c_SEG_0));
    check("rs_estado", 16'(db_estado), 16'(c_SEG_2));
    press(4'b0001);
    press(4'b0001); press(4'b0100);
    check("rs_err_estado", 16'(db_estado), 16'(c_SEG_E));
    check("rs_err_leds",   16'(bus.leds),  16'b0100);
    check("rs_err_limite", 16'(db_limite), 16'(c_SEG_1));

`ifdef TIMEOUT_EN
    bus.jogar = 1'b1;
    tick(1);
    bus.jogar = 1'b0;
    tick(2990);
    check("tmo_before", 16'(db_estado), 16'(c_SEG_2));
    tick(20);
    check("tmo_estado", 16'(db_estado),  16'h21);
    check("tmo_perdeu", 16'(bus.perdeu), 16'd1);
    check("tmo_flag",   16'(db_timeout), 16'd1);
    check("tmo_pronto", 16'(bus.pronto), 16'd1);
    check("tmo_ganhou", 16'(bus.ganhou), 16'd0);
`else
    bus.jogar = 1'b1;
    tick(1);
    bus.jogar = 1'b0;
    tick(3100);
    check("notmo_estado", 16'(db_estado),  16'(c_SEG_2));
    check("notmo_flag",   16'(db_timeout), 16'd0);
    check("notmo_pronto", 16'(bus.pronto), 16'd0);
`endif

    // Mid-game reset
    press(4'b0001);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    check("mrst_estado", 16'(db_estado),  16'(c_SEG_0));
    check("mrst_leds",   16'(bus.leds),   16'd0);
    check("mrst_limite", 16'(db_limite),  16'(c_SEG_0));
    check("mrst_pronto", 16'(bus.pronto), 16'd0);

    // Full 16-round winning game
    bus.jogar = 1'b1;
    tick(2);
    bus.jogar = 1'b0;
    tick(1);
    for (int r = 0; r < 16; r++) begin
      for (int e = 0; e <= r; e++) press(rom[e]);
      if (r == 14) begin
        check("r15_igualL", 16'(db_igualL), 16'd1);
        check("r15_limite", 16'(db_limite), 16'(c_SEG_F));
      end
    end
    check("win_estado", 16'(db_estado),  16'(c_SEG_A));
    check("win_ganhou", 16'(bus.ganhou), 16'd1);
    check("win_perdeu", 16'(bus.perdeu), 16'd0);
    check("win_pronto", 16'(bus.pronto), 16'd1);
    check("win_leds",   16'(bus.leds),   16'b0100);
    check("win_tmo",    16'(db_timeout), 16'd0);
    tick(5);
    check("win_hold", 16'(db_estado), 16'(c_SEG_A));

    bus.jogar = 1'b1;
    tick(2);
    bus.jogar = 1'b0;
    tick(1);
    check("again_estado", 16'(db_estado), 16'(c_SEG_2));
    check("again_leds",   16'(bus.leds),  16'd0);
    check("again_ganhou", 16'(bus.ganhou), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_circuito_exp5
`default_nettype wire
